// File: rtl/ss_adc_pkg.sv
// Shared types and constants for the single-slope ADC controller.
// Defining COMP_FILTER_EN enables the comparator run-length filter.
package ss_adc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RAMP   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_LEN    = 3;

`ifdef COMP_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // Number of counts between the comparator crossing and the qualified trip.
    function automatic int calc_lat(input int sync_stages, input int filter_len,
                                    input bit filter_en);
        return filter_en ? (sync_stages + filter_len - 1) : sync_stages;
    endfunction

endpackage

// File: rtl/ss_adc_comp_sync.sv
// Comparator synchroniser chain with an optional run-length glitch filter.
// Defining COMP_FILTER_EN requires FILTER_LEN consecutive high samples to trip.
module ss_adc_comp_sync
    import ss_adc_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic comp_in,
    output logic trip
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sample;

    always_comb begin
        sync_d = SYNC_STAGES'({sync_q, comp_in});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

`ifdef COMP_FILTER_EN
    localparam int RW = $clog2(FILTER_LEN) + 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_LEN - 1);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;

    // Run length saturates at FILTER_LEN-1; the next high sample is the trip.
    always_comb begin
        run_d = run_q;
        if (clr || !sample) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign trip = sample && (run_q == RUN_MAX);
`else
    // Without filtering the clear input and run length have no effect.
    logic filter_unused;
    assign filter_unused = clr & (FILTER_LEN > 0);
    assign trip          = sample;
`endif

endmodule

// File: rtl/ss_adc_ctrl.sv
// Single-slope ADC conversion controller: settle/ramp sequencing, counting,
// latency-corrected capture and overflow. COMP_FILTER_EN adds trip filtering.
module ss_adc_ctrl
    import ss_adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_LEN    = DEF_FILTER_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             comp_out,
    output logic             ramp_reset,
    output logic             ramp_en,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int LAT = calc_lat(SYNC_STAGES, FILTER_LEN, FILTER_EN);
    localparam int SW  = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [WIDTH-1:0] FULL      = '1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             in_ramp;
    logic             trip;
    logic [31:0]      count_ext;
    logic [WIDTH-1:0] corrected;

    assign in_ramp = (state_q == RAMP);

    ss_adc_comp_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_comp_sync (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_ramp),
        .comp_in (comp_out),
        .trip    (trip)
    );

    // Remove the synchroniser/filter delay, flooring at zero.
    always_comb begin
        count_ext = 32'(count_q);
        corrected = (count_ext >= 32'(LAT)) ? WIDTH'(count_ext - 32'(LAT)) : '0;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        settle_d   = settle_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = RAMP;
                    count_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RAMP: begin
                // A trip in the full-scale cycle still wins over overflow.
                if (trip) begin
                    state_d    = DONE;
                    result_d   = corrected;
                    overflow_d = 1'b0;
                end else if (count_q == FULL) begin
                    state_d    = DONE;
                    result_d   = FULL;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            settle_q   <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            settle_q   <= settle_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        ramp_reset = 1'b1;
        ramp_en    = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        if (!rst) begin
            ramp_reset = (state_q != RAMP);
            ramp_en    = (state_q == RAMP);
            busy       = (state_q != IDLE);
            valid      = (state_q == DONE);
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ss_adc_ctrl.sv
// Scoreboard bench for ss_adc_ctrl: comparator patterns are described per ramp
// count and a count-domain reference model predicts result, overflow and timing.
module tb_ss_adc_ctrl;

    localparam int S  = 2;
    localparam int SY = 2;
`ifdef COMP_FILTER_EN
    localparam int F = 3;
`else
    localparam int F = 1;
`endif
    localparam int LAT = SY + F - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       comp_out = 1'b0;
    logic       ramp_reset, ramp_en, busy, valid, overflow;
    logic [7:0] result;

    int compares = 0;
    int mismatches = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] res;
        bit         ov;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    bit pat [0:255];
    bit pre_lvl;

    ss_adc_ctrl #(
        .WIDTH(8), .SETTLE_CYCLES(S), .SYNC_STAGES(SY), .FILTER_LEN(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .comp_out(comp_out), .ramp_reset(ramp_reset), .ramp_en(ramp_en),
        .busy(busy), .valid(valid), .result(result), .overflow(overflow)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        compares++;
        if (act != exp) begin
            mismatches++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic fill_pat(input int from, input int to, input bit v);
        for (int i = from; i <= to && i < 256; i++) pat[i] = v;
    endtask

    // Trip at count n when the last F samples taken inside the ramp are all
    // high; a sample at count m reflects comp_out at count m-SY.
    function automatic void model(output int n_out, output logic [7:0] r, output bit o);
        for (int n = 0; n < 256; n++) begin
            bit hit;
            hit = (n >= F - 1);
            for (int j = 0; j < F; j++) begin
                int idx;
                bit lvl;
                idx = n - SY - j;
                lvl = (idx < 0) ? pre_lvl : pat[idx];
                if (!lvl) hit = 1'b0;
            end
            if (hit) begin
                n_out = n;
                r = (n >= LAT) ? 8'(n - LAT) : 8'd0;
                o = 1'b0;
                return;
            end
        end
        n_out = 255;
        r = 8'hFF;
        o = 1'b1;
    endfunction

    // Conversion whose RAMP count 0 falls on cycle k+1+S.
    task automatic drive_conv(input int k, output int due);
        int n;
        logic [7:0] r;
        bit o;
        exp_t e;
        model(n, r, o);
        due = k + 2 + S + n;
        e.res = r;
        e.ov = o;
        e.due = due;
        exp_q.push_back(e);
        $display("conv: start_cyc=%0d expect result=%0d overflow=%0d at cycle %0d", k, r, o, due);
        for (int c = 0; c <= n; c++) begin
            wait_cyc(k + 1 + S + c);
            comp_out = pat[c];
        end
    endtask

    task automatic single_conv();
        int k;
        int due;
        comp_out = pre_lvl;
        repeat (3) step();
        k = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        drive_conv(k, due);
        wait_cyc(due + 1);
        check("busy_after_valid", busy, 0);
        check("ramp_reset_idle", ramp_reset, 1);
        comp_out = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                compares++;
                mismatches++;
                $display("FAIL unexpected_valid: got valid=1 result=%0d, expected no valid (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", int'(result), int'(e.res));
                check("overflow", int'(overflow), int'(e.ov));
                check("valid_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        int k;
        int d1;
        int d2;
        int t;
        int g;

        // Reset and idle
        repeat (3) step();
        check("rst_ramp_reset", ramp_reset, 1);
        check("rst_ramp_en", ramp_en, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        rst = 1'b0;
        step();
        check("idle_ramp_reset", ramp_reset, 1);
        check("idle_ramp_en", ramp_en, 0);
        check("idle_busy", busy, 0);
        check("idle_result", result, 0);
        check("idle_overflow", overflow, 0);

        // Nominal trip at count 50
        pre_lvl = 1'b0;
        fill_pat(0, 255, 1'b0);
        fill_pat(50, 255, 1'b1);
        single_conv();

        // Abort in the middle of a ramp
        fill_pat(0, 255, 1'b0);
        repeat (3) step();
        k = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_cyc(k + 1 + S + 40);
        check("abort_ramp_en_before", ramp_en, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ramp_en", ramp_en, 0);
        check("abort_ramp_reset", ramp_reset, 1);
        check("abort_result", result, 0);
        check("abort_overflow", overflow, 0);
        repeat (20) step();

        // Full scale without a trip, then a normal conversion
        fill_pat(0, 255, 1'b0);
        single_conv();
        fill_pat(77, 255, 1'b1);
        single_conv();

        // Continuous mode: trips at 10 then 20, start pulses while busy
        fill_pat(0, 255, 1'b0);
        fill_pat(10, 255, 1'b1);
        continuous = 1'b1;
        repeat (3) step();
        k = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        drive_conv(k, d1);
        fill_pat(0, 255, 1'b0);
        fill_pat(20, 255, 1'b1);
        wait_cyc(d1);
        comp_out = 1'b0;
        start = 1'b1;
        step();
        check("cont_busy_after_done", busy, 1);
        check("cont_settle_ramp_reset", ramp_reset, 1);
        start = 1'b0;
        continuous = 1'b0;
        drive_conv(d1, d2);
        wait_cyc(d2 + 1);
        check("cont_busy_end", busy, 0);
        comp_out = 1'b0;

        // Comparator already high before start
        pre_lvl = 1'b1;
        fill_pat(0, 255, 1'b1);
        single_conv();
        pre_lvl = 1'b0;

        // Two-cycle glitch at 30, steady high from 60
        fill_pat(0, 255, 1'b0);
        fill_pat(30, 31, 1'b1);
        fill_pat(60, 255, 1'b1);
        single_conv();

        // Randomised thresholds, glitches and stale levels
        for (int it = 0; it < 10; it++) begin
            pre_lvl = ($urandom_range(0, 5) == 0);
            t = $urandom_range(0, 270);
            fill_pat(0, 255, pre_lvl);
            fill_pat(0, 255, 1'b0);
            if (t > 4 && $urandom_range(0, 1) == 1) begin
                g = $urandom_range(0, t - 4);
                fill_pat(g, g + $urandom_range(0, 1), 1'b1);
            end
            fill_pat(t, 255, 1'b1);
            single_conv();
        end

        repeat (5) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
